selen_dmem_resp: RTL
====================

SELEN_DMEM_RESP -- requirements
Module: selen_dmem_resp

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  BASE_ADDR, 32'h0000_0000, byte address of word 0.
  DEPTH_WORDS, 1024, storage depth in 32-bit words (power of 2, 2..65536).
  LATENCY, 1, cycles from request capture to ack for cop[1]=0 (1..15).
  NC_LATENCY, 3, cycles from request capture to ack for cop[1]=1 (1..15).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  clk  input  1  single clock, rising edge.
  reset  input  1  synchronous, active-high.
  d_req_val  input  1  request valid, held by initiator until ack.
  d_req_addr  input  32  byte address.
  d_req_cop  input  3  [0]=write, [1]=non-cacheable, [2]=reserved/ignored.
  d_req_wdata  input  32  lane-aligned store data, sampled in ack cycle.
  d_req_size  input  3  0=B,1=H,2=W,4=BU,5=HU; others illegal.
  d_req_ack  output  1  one-cycle completion pulse.
  d_ack_rdata  output  32  full aligned word, valid when d_req_ack=1.
  err  output  1  sticky error flag.
  busy  output  1  high in any state other than IDLE.

Function
REQ-003 FSM SHALL have states IDLE, WAIT, ACK.
REQ-004 IDLE with d_req_val=1 SHALL capture addr, cop, size; load counter with LATENCY or NC_LATENCY (by cop[1]) minus 1; go to WAIT if the loaded value is nonzero, else ACK.
REQ-005 WAIT SHALL decrement counter each cycle; go to ACK when counter reaches 0.
REQ-006 ACK SHALL assert d_req_ack for exactly one cycle, then return to IDLE.
REQ-007 ACK-to-next-capture SHALL be one cycle minimum: d_req_val seen in the IDLE cycle after ACK starts a new request.
REQ-008 Total latency: d_req_ack asserts exactly L cycles after the capture edge (L = selected latency).
REQ-009 Inputs during WAIT/ACK other than d_req_wdata SHALL be ignored; captured values govern.
REQ-010 Word index SHALL be (addr - BASE_ADDR) >> 2; in-range iff addr >= BASE_ADDR and index < DEPTH_WORDS.
REQ-011 Reads SHALL drive d_ack_rdata from a register loaded on ACK entry with the full stored word; addr[1:0] and size are ignored for data.
REQ-012 Writes SHALL update storage at the end of the ACK cycle using d_req_wdata sampled that cycle, under byte enables: size B/BU -> 1 lane at addr[1:0]; H/HU -> lanes {addr[1],0} and {addr[1],1}; W -> all 4.
REQ-013 Misaligned access (H with addr[0]=1; W with addr[1:0]!=0), illegal size, or out-of-range address SHALL complete with normal latency and ack, SHALL NOT modify storage, SHALL return 32'hDEAD_BEEF for reads, and SHALL set err.
REQ-014 err SHALL remain set until reset.
REQ-015 d_ack_rdata SHALL be 0 in all non-ACK cycles and for write acks.
REQ-016 cop[2] SHALL have no effect.

Reset
REQ-017 With reset=1 at a clock edge: state=IDLE, counter=0, d_req_ack=0, d_ack_rdata=0, err=0, busy=0.
REQ-018 Reset mid-request (WAIT or ACK) SHALL abort it: no ack, no storage write.
REQ-019 Storage contents SHALL NOT be cleared by reset.
REQ-020 d_req_val sampled in the reset cycle SHALL be ignored; capture starts the first non-reset cycle.

Verification
REQ-021 Word write/read: LATENCY=1, write W addr 0x10 data 0x1234_5678, then read 0x10 -> each ack 1 cycle after capture, rdata 0x1234_5678, err=0.
REQ-022 Byte/half lanes: write W 0x20=0xFFFF_FFFF, write B 0x21 data 0x0000_AB00, write H 0x22 data 0xCDEF_0000, read 0x20 -> 0xCDEF_ABFF.
REQ-023 NC latency: NC_LATENCY=3, read with cop=3'b010 -> ack exactly 3 cycles after capture; busy high for those 3 cycles.
REQ-024 Errors: read 0x4000_0000 (out of range, DEPTH 1024) -> ack, rdata 0xDEAD_BEEF, err=1; write W 0x32 -> storage at 0x30 unchanged.
REQ-025 Back-to-back: val held high across two reads -> second capture in the cycle after the first ack, acks spaced L+1 cycles.
REQ-026 Reset in WAIT: reset during a NC write -> no ack, target word unchanged on readback, err=0.

Source files
------------

// File: rtl/selen_dmem_resp.sv
// selen_dmem_resp: single-outstanding data memory responder with programmable latency and sticky error flag
module selen_dmem_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter int          NC_LATENCY  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_req_val,
  input  logic [31:0] d_req_addr,
  input  logic [2:0]  d_req_cop,
  input  logic [31:0] d_req_wdata,
  input  logic [2:0]  d_req_size,
  output logic        d_req_ack,
  output logic [31:0] d_ack_rdata,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, rdata_q;
  logic [1:0]  cop_q;
  logic [2:0]  size_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] addr_d;
  logic [29:0] woff;
  logic [1:0]  cop_d;
  logic [2:0]  size_d;
  logic [3:0]  lat_d, be;
  logic [AW-1:0] idx;
  logic        in_rng, algn, ok, go_ack, unused;
  assign unused = d_req_cop[2];
  // In IDLE the live request is about to be captured, elsewhere the captured copy governs
  always_comb begin
    addr_d = state_q == IDLE ? d_req_addr : addr_q;
    cop_d  = state_q == IDLE ? d_req_cop[1:0] : cop_q;
    size_d = state_q == IDLE ? d_req_size : size_q;
    lat_d  = cop_d[1] ? 4'(NC_LATENCY - 1) : 4'(LATENCY - 1);
    woff   = 30'((addr_d - BASE_ADDR) >> 2);
    idx    = woff[AW-1:0];
    in_rng = addr_d >= BASE_ADDR && woff < 30'(DEPTH_WORDS);
    algn   = size_d == 3'd0 || size_d == 3'd4 ||
             ((size_d == 3'd1 || size_d == 3'd5) && !addr_d[0]) ||
             (size_d == 3'd2 && addr_d[1:0] == 2'd0);
    ok     = in_rng && algn;
    be     = size_d[1] ? 4'hF : size_d[0] ? (4'b0011 << {addr_d[1], 1'b0}) : (4'b0001 << addr_d[1:0]);
    go_ack = (state_q == IDLE && d_req_val && lat_d == 4'd0) || (state_q == WAIT && cnt_q == 4'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      cop_q   <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= go_ack ? (cop_d[0] ? 32'h0 : ok ? mem_q[idx] : 32'hDEAD_BEEF) : 32'h0;
      err_q   <= err_q | (go_ack & ~ok);
      case (state_q)
        IDLE: if (d_req_val) begin
          addr_q  <= d_req_addr;
          cop_q   <= d_req_cop[1:0];
          size_q  <= d_req_size;
          cnt_q   <= lat_d;
          state_q <= lat_d != 4'd0 ? WAIT : ACK;
        end
        WAIT: begin
          cnt_q   <= cnt_q - 4'd1;
          state_q <= cnt_q == 4'd1 ? ACK : WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state_q == ACK && cop_q[0] && ok)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= d_req_wdata[8*b +: 8];
  end
  assign d_req_ack   = state_q == ACK;
  assign d_ack_rdata = rdata_q;
  assign err         = err_q;
  assign busy        = state_q != IDLE;
endmodule
